// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: default field
// widths, the hazard-carrying entry layout, bubble value and Tnew countdown.
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;
  localparam int TNEW_W      = 3;
  localparam int TUSE_W      = 3;
  localparam int TUSE_IDLE   = 4;

  // Occupancy view of a stage: derived from the entry valid bits, never stored.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic                   valid;
    logic [PIPE_DATA_W-1:0] data;
    logic [4:0]             dst;
    logic [TNEW_W-1:0]      tnew;
    logic [TUSE_W-1:0]      rs_tuse;
    logic [TUSE_W-1:0]      rt_tuse;
  } pipe_entry_t;

  // A bubble never produces a result and never consumes one.
  localparam pipe_entry_t BUBBLE_ENTRY = '{
    valid:   1'b0,
    data:    '0,
    dst:     5'd0,
    tnew:    '0,
    rs_tuse: TUSE_W'(TUSE_IDLE),
    rt_tuse: TUSE_W'(TUSE_IDLE)
  };

  // Tnew countdown that sticks at zero instead of wrapping.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    if (x == '0) return '0;
    return x - 1'b1;
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with ready/valid handshake, a one-entry skid
// buffer, synchronous flush and hazard metadata (dst, Tnew, Tuse rs/rt).
// Outputs and in_ready are pure register outputs; invalid entries hold
// bubble values so the hazard unit can read fields without qualification.
module pipe_stage_skid #(
  parameter int DATA_W      = pipe_pkg::PIPE_DATA_W,
  parameter int TNEW_W      = pipe_pkg::TNEW_W,
  parameter int TUSE_W      = pipe_pkg::TUSE_W,
  parameter int TUSE_IDLE   = pipe_pkg::TUSE_IDLE,
  parameter int AGE_ON_HOLD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_dst,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [TUSE_W-1:0] in_rs_tuse,
  input  logic [TUSE_W-1:0] in_rt_tuse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_dst,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [TUSE_W-1:0] out_rs_tuse,
  output logic [TUSE_W-1:0] out_rt_tuse,
  output logic              out_fwd_ok,
  output logic [1:0]        occupancy
);
  import pipe_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [4:0]        dst;
    logic [TNEW_W-1:0] tnew;
    logic [TUSE_W-1:0] rs_tuse;
    logic [TUSE_W-1:0] rt_tuse;
  } entry_t;

  function automatic entry_t bubble();
    entry_t e;
    e.valid   = 1'b0;
    e.data    = '0;
    e.dst     = 5'd0;
    e.tnew    = '0;
    e.rs_tuse = TUSE_W'(TUSE_IDLE);
    e.rt_tuse = TUSE_W'(TUSE_IDLE);
    return e;
  endfunction

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] x);
    if (x == '0) return '0;
    return x - 1'b1;
  endfunction

  // Entries sitting still age only when the stage feeds a multi-cycle unit.
  function automatic entry_t hold_age(input entry_t e);
    entry_t r;
    r = e;
    if (AGE_ON_HOLD != 0) r.tnew = tnew_dec(e.tnew);
    return r;
  endfunction

  entry_t     r_main;
  entry_t     r_skid;
  logic       r_in_ready;
  logic       r_fwd_ok;
  logic [1:0] r_occ;

  entry_t     w_cap;
  entry_t     w_main_n;
  entry_t     w_skid_n;
  occ_state_e w_state;
  logic       w_accept;
  logic       w_drain;

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = r_main.valid && out_ready;

  // Incoming beat as it will be stored: Tnew advanced by one stage.
  always_comb begin
    w_cap         = bubble();
    w_cap.valid   = 1'b1;
    w_cap.data    = in_data;
    w_cap.dst     = in_dst;
    w_cap.tnew    = tnew_dec(in_tnew);
    w_cap.rs_tuse = in_rs_tuse;
    w_cap.rt_tuse = in_rt_tuse;
  end

  // Occupancy state decoded from the two valid bits.
  always_comb begin
    w_state = ST_EMPTY;
    if (r_skid.valid)      w_state = ST_FULL;
    else if (r_main.valid) w_state = ST_ONE;
  end

  // Next main/skid contents; flush empties the stage but a drain still counts.
  always_comb begin
    w_main_n = hold_age(r_main);
    w_skid_n = hold_age(r_skid);
    if (flush) begin
      w_main_n = bubble();
      w_skid_n = bubble();
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_accept) w_main_n = w_cap;
        end
        ST_ONE: begin
          if (w_accept && w_drain) w_main_n = w_cap;
          else if (w_accept)       w_skid_n = w_cap;
          else if (w_drain)        w_main_n = bubble();
        end
        ST_FULL: begin
          if (w_drain) begin
            w_main_n = r_skid;
            w_skid_n = bubble();
          end
        end
        default: begin
          w_main_n = bubble();
          w_skid_n = bubble();
        end
      endcase
    end
  end

  // Stage registers; reset drops both entries immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main     <= bubble();
      r_skid     <= bubble();
      r_in_ready <= 1'b1;
      r_fwd_ok   <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_main     <= w_main_n;
      r_skid     <= w_skid_n;
      r_in_ready <= !w_skid_n.valid;
      r_fwd_ok   <= w_main_n.valid && (w_main_n.dst != 5'd0) && (w_main_n.tnew == '0);
      r_occ      <= {1'b0, w_main_n.valid} + {1'b0, w_skid_n.valid};
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main.valid;
  assign out_data    = r_main.data;
  assign out_dst     = r_main.dst;
  assign out_tnew    = r_main.tnew;
  assign out_rs_tuse = r_main.rs_tuse;
  assign out_rt_tuse = r_main.rt_tuse;
  assign out_fwd_ok  = r_fwd_ok;
  assign occupancy   = r_occ;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances (hold-constant and hold-aging
// Tnew) share one stimulus stream and are compared with a queue model.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic [4:0]  in_dst;
  logic [2:0]  in_tnew, in_rs_tuse, in_rt_tuse;

  logic [1:0]  o_in_ready, o_valid, o_fwd;
  logic [63:0] o_data [2];
  logic [4:0]  o_dst  [2];
  logic [2:0]  o_tnew [2];
  logic [2:0]  o_rs   [2];
  logic [2:0]  o_rt   [2];
  logic [1:0]  o_occ  [2];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  dst;
    logic [2:0]  tn;
    logic [2:0]  rs;
    logic [2:0]  rt;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(64), .TNEW_W(3), .TUSE_W(3), .TUSE_IDLE(4), .AGE_ON_HOLD(0)) u_hold (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(o_in_ready[0]),
    .in_data(in_data), .in_dst(in_dst), .in_tnew(in_tnew),
    .in_rs_tuse(in_rs_tuse), .in_rt_tuse(in_rt_tuse),
    .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_data(o_data[0]), .out_dst(o_dst[0]), .out_tnew(o_tnew[0]),
    .out_rs_tuse(o_rs[0]), .out_rt_tuse(o_rt[0]),
    .out_fwd_ok(o_fwd[0]), .occupancy(o_occ[0])
  );

  pipe_stage_skid #(.DATA_W(64), .TNEW_W(3), .TUSE_W(3), .TUSE_IDLE(4), .AGE_ON_HOLD(1)) u_age (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(o_in_ready[1]),
    .in_data(in_data), .in_dst(in_dst), .in_tnew(in_tnew),
    .in_rs_tuse(in_rs_tuse), .in_rt_tuse(in_rt_tuse),
    .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_data(o_data[1]), .out_dst(o_dst[1]), .out_tnew(o_tnew[1]),
    .out_rs_tuse(o_rs[1]), .out_rt_tuse(o_rt[1]),
    .out_fwd_ok(o_fwd[1]), .occupancy(o_occ[1])
  );

  function automatic logic [2:0] sdec(input logic [2:0] x);
    return (x == 3'd0) ? 3'd0 : x - 3'd1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [63:0] d, input logic [4:0] dst,
                       input logic [2:0] tn, input logic [2:0] rs, input logic [2:0] rt,
                       input logic ordy, input logic fl);
    in_valid   = iv;
    in_data    = d;
    in_dst     = dst;
    in_tnew    = tn;
    in_rs_tuse = rs;
    in_rt_tuse = rt;
    out_ready  = ordy;
    flush      = fl;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      ent_t q[$];
      ent_t e;
      logic ev;
      if (k == 0) q = q0; else q = q1;
      ev = (q.size() > 0);
      if (ev) e = q[0];
      else    e = '{64'd0, 5'd0, 3'd0, 3'd4, 3'd4};
      chk($sformatf("u%0d.out_valid", k), 64'(o_valid[k]), 64'(ev));
      chk($sformatf("u%0d.out_data", k), o_data[k], e.d);
      chk($sformatf("u%0d.out_dst", k), 64'(o_dst[k]), 64'(e.dst));
      chk($sformatf("u%0d.out_tnew", k), 64'(o_tnew[k]), 64'(e.tn));
      chk($sformatf("u%0d.out_rs_tuse", k), 64'(o_rs[k]), 64'(e.rs));
      chk($sformatf("u%0d.out_rt_tuse", k), 64'(o_rt[k]), 64'(e.rt));
      chk($sformatf("u%0d.out_fwd_ok", k), 64'(o_fwd[k]),
          64'(ev && e.dst != 5'd0 && e.tn == 3'd0));
      chk($sformatf("u%0d.occupancy", k), 64'(o_occ[k]), 64'(q.size()));
      chk($sformatf("u%0d.in_ready", k), 64'(o_in_ready[k]), 64'(q.size() < 2));
    end
  endtask

  // One clock: model decides from pre-edge state, then outputs are checked.
  task automatic step();
    ent_t e;
    ent_t dmy;
    ent_t q[$];
    bit   acc, drn;
    e = '{in_data, in_dst, sdec(in_tnew), in_rs_tuse, in_rt_tuse};
    for (int k = 0; k < 2; k++) begin
      if (k == 0) q = q0; else q = q1;
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) dmy = q.pop_front();
        else if (k == 1) foreach (q[i]) q[i].tn = sdec(q[i].tn);
        if (acc) q.push_back(e);
      end
      if (k == 0) q0 = q; else q1 = q;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin : main
    logic [2:0] exp_age [4];
    logic       exp_fwd [4];
    exp_age = '{3'd2, 3'd1, 3'd0, 3'd0};
    exp_fwd = '{1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b0;
    drive(1'b0, 64'd0, 5'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    #12;
    check_all();
    @(negedge clk) reset = 1'b1;

    // first beat: Tnew 2 captured as 1
    drive(1'b1, 64'h0000_00A5_DEAD_BEEF, 5'd5, 3'd2, 3'd1, 3'd2, 1'b1, 1'b0);
    step();
    chk("first.out_valid", 64'(o_valid[0]), 64'd1);
    chk("first.out_dst", 64'(o_dst[0]), 64'd5);
    chk("first.out_tnew", 64'(o_tnew[0]), 64'd1);
    chk("first.out_fwd_ok", 64'(o_fwd[0]), 64'd0);

    // streaming at full rate
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {$urandom, $urandom}, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, 1'b0);
      step();
      chk("stream.occupancy", 64'(o_occ[0]), 64'd1);
    end
    drive(1'b0, 64'd0, 5'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    step();

    // backpressure fills the skid entry, then drains in order
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h1000 + 64'(i), 5'(i + 1), 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);
      step();
      chk("bp.occupancy", 64'(o_occ[0]), (i == 0) ? 64'd1 : 64'd2);
    end
    chk("bp.in_ready", 64'(o_in_ready[0]), 64'd0);
    drive(1'b0, 64'd0, 5'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    step();
    chk("bp.drain0", o_data[0], 64'h1001);
    step();
    step();

    // flush while full with a drain and an input beat in the same cycle
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h2000 + 64'(i), 5'd9, 3'd3, 3'd1, 3'd1, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 64'h2FFF, 5'd9, 3'd3, 3'd1, 3'd1, 1'b1, 1'b1);
    step();
    chk("flush.occupancy", 64'(o_occ[0]), 64'd0);
    chk("flush.out_rs_tuse", 64'(o_rs[0]), 64'd4);
    chk("flush.in_ready", 64'(o_in_ready[0]), 64'd1);

    // Tnew aging while held
    drive(1'b1, 64'h3333, 5'd7, 3'd3, 3'd0, 3'd1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("age.on.out_tnew", 64'(o_tnew[1]), 64'(exp_age[i]));
      chk("age.on.out_fwd_ok", 64'(o_fwd[1]), 64'(exp_fwd[i]));
      chk("age.off.out_tnew", 64'(o_tnew[0]), 64'd2);
      chk("age.off.out_fwd_ok", 64'(o_fwd[0]), 64'd0);
      drive(1'b0, 64'd0, 5'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    end
    drive(1'b0, 64'd0, 5'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      step();
    end

    // asynchronous reset while full
    drive(1'b0, 64'd0, 5'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h4000 + 64'(i), 5'd3, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0);
      step();
    end
    chk("rst.pre.occupancy", 64'(o_occ[0]), 64'd2);
    drive(1'b0, 64'd0, 5'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    check_all();
    chk("rst.async.in_ready", 64'(o_in_ready[1]), 64'd1);
    @(negedge clk) reset = 1'b1;
    drive(1'b1, 64'h5555, 5'd4, 3'd1, 3'd2, 3'd2, 1'b1, 1'b0);
    step();
    chk("rst.after.out_fwd_ok", 64'(o_fwd[0]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
